// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_seq_pkg
// Description : Shared constants and types for the sliced-adder sequencer.
//               SLICE_W is the width of the external combinational
//               prefix adder.
// Revision    : 1.0  initial release
// ============================================================================
package adder_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/adder_slice_seq.sv
`default_nettype none
// ============================================================================
// Module      : adder_slice_seq
// Description : Multi-cycle WIDTH-bit adder built around an external,
//               purely combinational SLICE-bit adder. One slice is added per
//               cycle, LSB slice first, with the slice carry-out fed back in
//               as the next slice's carry-in.
// Ports       : clk, rst_n             clock / async active-low reset
//               in_valid/in_ready     operand handshake (a, b, cin)
//               out_valid/out_ready   result handshake (sum, cout, ovf)
//               add_a/add_b/add_cin   drive the external slice adder
//               add_sum/add_cout      its same-cycle result
// Revision    : 1.0  initial release
// ============================================================================
module adder_slice_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    input  logic [SLICE-1:0] add_sum,
    input  logic             add_cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

    // Reject widths the slice sequencing cannot cover exactly.
    if ((WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_width
        $error("adder_slice_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    seq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_last;

    // A finished result may be swapped for a new operand set in the same
    // cycle it is handed off, so DONE accepts when downstream is ready.
    assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == C_LAST_IDX);

    // Adder inputs are forced to zero outside RUN so the external adder
    // does not toggle while the sequencer is idle or holding a result.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_a   = r_a[r_idx*SLICE +: SLICE];
            add_b   = r_b[r_idx*SLICE +: SLICE];
            add_cin = r_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_a         <= a;
            r_b         <= b;
            r_carry     <= cin;
            r_idx       <= '0;
            r_state     <= RUN;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_sum[r_idx*SLICE +: SLICE] <= add_sum;
                    r_carry                     <= add_cout;
                    if (w_last) begin
                        // Overflow uses the MSB of the slice being written
                        // now, since r_sum does not hold it yet.
                        r_cout      <= add_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (add_sum[SLICE-1] != r_a[WIDTH-1]);
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule : adder_slice_seq
`default_nettype wire
